// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and default widths for the round-robin memory request arbiter.
package mem_req_arbiter_pkg;

    localparam int MEM_ADDR_W = 2;
    localparam int MEM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic                  write;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Requester handshake plus memory bus seen by the arbiter (slave) and its environment (master).
interface mem_req_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_wr_en;
    logic                      mem_rd_en;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wr_en, mem_rd_en, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wr_en, mem_rd_en, mem_wdata
    );
endinterface

// File: rtl/mem_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after the pointer, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o
);
    logic found_s;
    int   cand_s;

    // Scan requesters in priority order starting just after the pointer
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found_s = 1'b0;
        cand_s  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s = (int'(ptr_i) + k) % NUM_REQ;
            if (!found_s && req_i[cand_s]) begin
                found_s         = 1'b1;
                grant_o[cand_s] = 1'b1;
                idx_o           = IDX_W'(cand_s);
            end else begin
                found_s = found_s;
            end
        end
    end
endmodule

// File: rtl/mem_req_arbiter.sv
// Shares a single-port memory between NUM_REQ requesters, one transaction at a time.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W,
    parameter int RD_LAT  = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    mem_req_arbiter_if.slave   bus,
    output logic               busy_o
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    mem_cmd_t            cmd_q, cmd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_wr_en_q, mem_wr_en_d;
    logic                mem_rd_en_q, mem_rd_en_d;
    logic                busy_q, busy_d;
    logic [NUM_REQ-1:0]  grant_s;
    logic [IDX_W-1:0]    gnt_idx_s;
    logic [NUM_REQ-1:0]  req_ready_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req_i   (bus.req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant_s),
        .idx_o   (gnt_idx_s)
    );

    // Next-state and registered-output logic of the transaction FSM
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        cmd_d       = cmd_q;
        cnt_d       = cnt_q;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wr_en_d = 1'b0;
        mem_rd_en_d = 1'b0;
        req_ready_s = '0;
        case (state_q)
            IDLE: begin
                // Gated by reset so no grant is offered while reset is held
                req_ready_s = reset_i ? '0 : grant_s;
                if (|grant_s) begin
                    cmd_d.write = bus.req_write[gnt_idx_s];
                    cmd_d.addr  = bus.req_addr[int'(gnt_idx_s)*ADDR_W +: ADDR_W];
                    cmd_d.wdata = bus.req_wdata[int'(gnt_idx_s)*DATA_W +: DATA_W];
                    gnt_d       = grant_s;
                    ptr_d       = gnt_idx_s;
                    mem_addr_d  = bus.req_addr[int'(gnt_idx_s)*ADDR_W +: ADDR_W];
                    mem_wdata_d = bus.req_wdata[int'(gnt_idx_s)*DATA_W +: DATA_W];
                    mem_wr_en_d = bus.req_write[gnt_idx_s];
                    mem_rd_en_d = !bus.req_write[gnt_idx_s];
                    state_d     = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (cmd_q.write) begin
                    rsp_valid_d = gnt_q;
                    state_d     = RESP;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp_valid_d = gnt_q;
                    rsp_rdata_d = bus.mem_rdata;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            gnt_q       <= '0;
            cmd_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_en_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_rd_en_q <= mem_rd_en_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wr_en = mem_wr_en_q;
    assign bus.mem_rd_en = mem_rd_en_q;
    assign busy_o        = busy_q;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench: two arbiter builds (RD_LAT=1 and RD_LAT=3), each with its own 4x8 memory model.
module tb_mem_req_arbiter;
    logic       clk;
    logic       reset_s;
    logic       busy_s [2];
    int         n_cmp;
    int         n_err;

    logic [1:0] req_valid_s [2];
    logic [1:0] req_write_s [2];
    logic [3:0] req_addr_s  [2];
    logic [15:0] req_wdata_s [2];

    logic [1:0] rdy_s [2];
    logic [1:0] rspv_s [2];
    logic [7:0] rspd_s [2];
    logic [1:0] maddr_s [2];
    logic [7:0] mwdata_s [2];
    logic       mwr_s [2];
    logic       mrd_s [2];

    logic [7:0] mem_a [4];
    logic [7:0] mem_b [4];
    logic [7:0] pa0;
    logic [7:0] pb0, pb1, pb2;

    mem_req_arbiter_if #(.NUM_REQ(2), .ADDR_W(2), .DATA_W(8)) ifa ();
    mem_req_arbiter_if #(.NUM_REQ(2), .ADDR_W(2), .DATA_W(8)) ifb ();

    mem_req_arbiter #(.NUM_REQ(2), .ADDR_W(2), .DATA_W(8), .RD_LAT(1)) dut_a (
        .clk_i(clk), .reset_i(reset_s), .bus(ifa.slave), .busy_o(busy_s[0])
    );
    mem_req_arbiter #(.NUM_REQ(2), .ADDR_W(2), .DATA_W(8), .RD_LAT(3)) dut_b (
        .clk_i(clk), .reset_i(reset_s), .bus(ifb.slave), .busy_o(busy_s[1])
    );

    assign ifa.req_valid = req_valid_s[0];
    assign ifa.req_write = req_write_s[0];
    assign ifa.req_addr  = req_addr_s[0];
    assign ifa.req_wdata = req_wdata_s[0];
    assign ifb.req_valid = req_valid_s[1];
    assign ifb.req_write = req_write_s[1];
    assign ifb.req_addr  = req_addr_s[1];
    assign ifb.req_wdata = req_wdata_s[1];

    assign rdy_s[0] = ifa.req_ready;   assign rdy_s[1] = ifb.req_ready;
    assign rspv_s[0] = ifa.rsp_valid;  assign rspv_s[1] = ifb.rsp_valid;
    assign rspd_s[0] = ifa.rsp_rdata;  assign rspd_s[1] = ifb.rsp_rdata;
    assign maddr_s[0] = ifa.mem_addr;  assign maddr_s[1] = ifb.mem_addr;
    assign mwdata_s[0] = ifa.mem_wdata; assign mwdata_s[1] = ifb.mem_wdata;
    assign mwr_s[0] = ifa.mem_wr_en;   assign mwr_s[1] = ifb.mem_wr_en;
    assign mrd_s[0] = ifa.mem_rd_en;   assign mrd_s[1] = ifb.mem_rd_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory A: data valid one cycle after the edge that ends the read strobe
    always @(posedge clk) begin
        if (ifa.mem_wr_en) mem_a[ifa.mem_addr] <= ifa.mem_wdata;
        pa0 <= ifa.mem_rd_en ? mem_a[ifa.mem_addr] : 8'h00;
    end
    assign ifa.mem_rdata = pa0;

    // Memory B: three-stage read pipeline
    always @(posedge clk) begin
        if (ifb.mem_wr_en) mem_b[ifb.mem_addr] <= ifb.mem_wdata;
        pb0 <= ifb.mem_rd_en ? mem_b[ifb.mem_addr] : 8'h00;
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign ifb.mem_rdata = pb2;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mwr_s[0] && mrd_s[0]) check_val("strobe_overlap_a", 32'd1, 32'd0);
        if (mwr_s[1] && mrd_s[1]) check_val("strobe_overlap_b", 32'd1, 32'd0);
    end

    // One request from requester r on build s; entered and left just after a posedge, DUT idle
    task automatic txn(input int s, input int r, input bit wr, input logic [1:0] a,
                       input logic [7:0] d, input logic [7:0] exp_rd);
        int lat;
        lat = (s == 1) ? 3 : 1;
        req_valid_s[s]          = 2'b00;
        req_valid_s[s][r]       = 1'b1;
        req_write_s[s][r]       = wr;
        req_addr_s[s][r*2 +: 2] = a;
        req_wdata_s[s][r*8 +: 8] = d;
        @(negedge clk);
        check_val("ready_onehot", 32'(rdy_s[s]), 32'(1 << r));
        @(posedge clk); #1;
        req_valid_s[s] = 2'b00;
        @(negedge clk);
        check_val("issue_wr_en", 32'(mwr_s[s]), 32'(wr));
        check_val("issue_rd_en", 32'(mrd_s[s]), 32'(!wr));
        check_val("issue_addr", 32'(maddr_s[s]), 32'(a));
        check_val("issue_busy", 32'(busy_s[s]), 32'd1);
        check_val("issue_ready", 32'(rdy_s[s]), 32'd0);
        if (wr) begin
            check_val("issue_wdata", 32'(mwdata_s[s]), 32'(d));
        end else begin
            repeat (lat) begin
                @(negedge clk);
                check_val("wait_no_rsp", 32'(rspv_s[s]), 32'd0);
            end
        end
        @(negedge clk);
        check_val("rsp_valid", 32'(rspv_s[s]), 32'(1 << r));
        check_val("rsp_rdata", 32'(rspd_s[s]), wr ? 32'd0 : 32'(exp_rd));
        check_val("rsp_strobes", 32'({mwr_s[s], mrd_s[s]}), 32'd0);
        @(negedge clk);
        check_val("post_busy", 32'(busy_s[s]), 32'd0);
        check_val("post_rsp", 32'(rspv_s[s]), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [1:0] seen;
        int         er;
        n_cmp = 0;
        n_err = 0;
        for (int s = 0; s < 2; s++) begin
            req_valid_s[s] = 2'b00;
            req_write_s[s] = 2'b00;
            req_addr_s[s]  = 4'h0;
            req_wdata_s[s] = 16'h0000;
        end

        // 1: reset held with both requesters asking
        reset_s = 1'b1;
        req_valid_s[0] = 2'b11;
        repeat (3) begin
            @(negedge clk);
            check_val("rst_ready", 32'(rdy_s[0]), 32'd0);
            check_val("rst_rsp", 32'(rspv_s[0]), 32'd0);
            check_val("rst_strobes", 32'({mwr_s[0], mrd_s[0]}), 32'd0);
            check_val("rst_busy", 32'(busy_s[0]), 32'd0);
        end
        @(posedge clk); #1;
        req_valid_s[0] = 2'b00;
        reset_s = 1'b0;

        // 2: write then read back through requester 0
        txn(0, 0, 1'b1, 2'd2, 8'hA5, 8'h00);
        txn(0, 0, 1'b0, 2'd2, 8'h00, 8'hA5);

        // 3: both requesters continuously valid alternate from req0 after reset
        reset_s = 1'b1;
        @(posedge clk); #1;
        reset_s = 1'b0;
        req_write_s[0] = 2'b11;
        req_addr_s[0]  = {2'd1, 2'd0};
        req_wdata_s[0] = {8'h22, 8'h11};
        req_valid_s[0] = 2'b11;
        for (int k = 0; k < 4; k++) begin
            er = k % 2;
            @(negedge clk);
            check_val("rr_grant", 32'(rdy_s[0]), 32'(1 << er));
            @(posedge clk); #1;
            @(negedge clk);
            check_val("rr_addr", 32'(maddr_s[0]), 32'(er));
            check_val("rr_wdata", 32'(mwdata_s[0]), (er == 1) ? 32'h22 : 32'h11);
            @(negedge clk);
            check_val("rr_rsp", 32'(rspv_s[0]), 32'(1 << er));
        end
        @(posedge clk); #1;
        req_valid_s[0] = 2'b00;
        txn(0, 0, 1'b0, 2'd0, 8'h00, 8'h11);
        txn(0, 1, 1'b0, 2'd1, 8'h00, 8'h22);

        // 4: requester 1 fills every address then reads them back
        for (int a = 0; a < 4; a++) txn(0, 1, 1'b1, 2'(a), 8'h10 + 8'(a), 8'h00);
        for (int a = 0; a < 4; a++) txn(0, 1, 1'b0, 2'(a), 8'h00, 8'h10 + 8'(a));

        // 5: reset during the wait phase of a read aborts it silently
        req_write_s[0][0] = 1'b0;
        req_addr_s[0][1:0] = 2'd1;
        req_valid_s[0] = 2'b01;
        @(negedge clk);
        check_val("ab_ready", 32'(rdy_s[0]), 32'd1);
        @(posedge clk); #1;
        req_valid_s[0] = 2'b00;
        @(posedge clk); #1;
        reset_s = 1'b1;
        @(negedge clk);
        check_val("ab_wait_busy", 32'(busy_s[0]), 32'd1);
        @(posedge clk); #1;
        reset_s = 1'b0;
        @(negedge clk);
        check_val("ab_busy", 32'(busy_s[0]), 32'd0);
        check_val("ab_rsp", 32'(rspv_s[0]), 32'd0);
        check_val("ab_strobes", 32'({mwr_s[0], mrd_s[0]}), 32'd0);
        seen = 2'b00;
        repeat (5) begin
            @(negedge clk);
            seen = seen | rspv_s[0];
        end
        check_val("ab_no_rsp", 32'(seen), 32'd0);
        @(posedge clk); #1;
        txn(0, 0, 1'b0, 2'd3, 8'h00, 8'h13);

        // 6: three-cycle read latency build
        txn(1, 0, 1'b1, 2'd3, 8'h5C, 8'h00);
        txn(1, 0, 1'b0, 2'd3, 8'h00, 8'h5C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
